noc_buffer_out: RTL and testbench
=================================

NOC_BUFFER_OUT -- requirements
Module: noc_buffer_out

Interface
REQ-001 SHALL have parameter BW, default 32, stream data width in bits.
REQ-002 SHALL have parameter BWB, default BW/8, keep width.
REQ-003 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, >=4).
REQ-004 SHALL have port clk_line  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port clk_line_rst_low  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports stream_in_TVALID/TDATA/TKEEP/TLAST  input  1/BW/BWB/1  packet beats from the accelerator.
REQ-007 SHALL have port stream_in_TREADY  output  1  beat accepted when high together with TVALID.
REQ-008 SHALL have ports stream_out_TVALID/TDATA/TKEEP/TLAST  output  1/BW/BWB/1  beats toward the NoC router.
REQ-009 SHALL have port stream_out_TREADY  input  1  router backpressure.
REQ-010 SHALL have port buf_level  output  $clog2(DEPTH)+1  current entry count.

Function
REQ-011 SHALL store {TDATA,TKEEP,TLAST} per entry in a first-word-fall-through FIFO; head entry drives stream_out_TDATA/TKEEP/TLAST combinationally.
REQ-012 SHALL drive stream_in_TREADY = (buf_level != DEPTH); a full FIFO accepts no beat, even if an output pop happens in the same cycle.
REQ-013 SHALL keep pkt_count (width $clog2(DEPTH)+1): +1 on accepted input beat with TLAST, -1 on output handshake with TLAST; simultaneous +1/-1 leaves it unchanged.
REQ-014 SHALL implement output FSM OUT_IDLE/OUT_PKT: OUT_IDLE->OUT_PKT on output handshake with TLAST=0; OUT_PKT->OUT_IDLE on output handshake with TLAST=1; otherwise hold.
REQ-015 SHALL assert stream_out_TVALID = !empty && (pkt_count!=0 || state==OUT_PKT || full); store-and-forward normally, cut-through once full or mid-packet.
REQ-016 SHALL, once TVALID is high, hold TVALID and head data stable until handshake (AXI-Stream rule).
REQ-017 SHALL, in OUT_PKT with FIFO empty, drop TVALID without leaving OUT_PKT and resume when a beat arrives.
REQ-018 SHALL add zero cycles of latency in cut-through: a beat written at edge N is presentable on stream_out during cycle N+1.
REQ-019 SHALL wrap read/write pointers modulo DEPTH; buf_level = writes minus reads, range 0..DEPTH.
REQ-020 SHALL have a 1-cycle minimum input-to-output latency for a single-beat packet (write at edge N, TVALID during cycle N+1).

Reset
REQ-021 SHALL, on clk_line_rst_low low, asynchronously clear pointers, buf_level, pkt_count and the FSM (OUT_IDLE), discarding all stored beats, including any partial packet.
REQ-022 SHALL drive during reset: stream_out_TVALID=0, stream_out_TLAST=0, stream_in_TREADY=1 once reset is released, and buf_level=0.
REQ-023 SHALL not require clearing the storage array; stream_out_TDATA/TKEEP are don't-care while TVALID=0.

Configuration
REQ-024 SHALL, with macro NOC_BUF_OUT_STATS_EN defined, add output ports pkt_in_cnt and pkt_out_cnt (16 bits each), reset to 0, incremented on TLAST input/output handshakes, saturating at 16'hFFFF.
REQ-025 SHALL, without NOC_BUF_OUT_STATS_EN, omit those ports and counters; all other behaviour is identical.

Verification
REQ-026 SHALL cover: 2-beat packet {32'hA5000000, 32'h12345678, TLAST on beat 2}, TREADY_out=1 -> out TVALID first high the cycle after beat 2 is written; beats are emitted in order with TLAST on beat 2.
REQ-027 SHALL cover: TREADY_out=0, push 16 single-beat packets -> in TREADY low at buf_level=16; the 17th beat is stalled; release -> 16 beats emitted in order.
REQ-028 SHALL cover: 20-beat packet, DEPTH=16, TREADY_out=1 -> cut-through starts when full, and all 20 beats arrive with TLAST only on beat 20.
REQ-029 SHALL cover: simultaneous push of a TLAST beat and pop of a TLAST beat with pkt_count=1 -> pkt_count stays 1, buf_level unchanged.
REQ-030 SHALL cover: reset asserted mid-packet (3 of 5 beats stored) -> TVALID=0, buf_level=0, FSM OUT_IDLE; a following 1-beat packet passes normally.
REQ-031 SHALL cover, with NOC_BUF_OUT_STATS_EN defined: 3 packets in and out -> pkt_in_cnt=3, pkt_out_cnt=3; counters are preloaded near saturation -> they hold 16'hFFFF.

Source files
------------

// File: rtl/noc_buffer_out.sv
// noc_buffer_out: first-word-fall-through AXI-Stream buffer between an accelerator and a NoC router.
// Store-and-forward per packet, cut-through when full or mid-packet. Optional stats: NOC_BUF_OUT_STATS_EN.
module noc_buffer_out #(
  parameter int BW    = 32,
  parameter int BWB   = BW / 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_line,
  input  logic                     clk_line_rst_low,

  input  logic                     stream_in_TVALID,
  input  logic [BW-1:0]            stream_in_TDATA,
  input  logic [BWB-1:0]           stream_in_TKEEP,
  input  logic                     stream_in_TLAST,
  output logic                     stream_in_TREADY,

  output logic                     stream_out_TVALID,
  output logic [BW-1:0]            stream_out_TDATA,
  output logic [BWB-1:0]           stream_out_TKEEP,
  output logic                     stream_out_TLAST,
  input  logic                     stream_out_TREADY,

  output logic [$clog2(DEPTH):0]   buf_level
`ifdef NOC_BUF_OUT_STATS_EN
  ,
  output logic [15:0]              pkt_in_cnt,
  output logic [15:0]              pkt_out_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [BW-1:0]  data;
    logic [BWB-1:0] keep;
    logic           last;
  } entry_t;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_PKT  = 1'b1
  } out_state_e;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  entry_t        in_entry;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] pkt_count_q, pkt_count_d;
  out_state_e    state_q, state_d;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          in_last;
  logic          out_last;

  // Handshake and head-of-queue decode. The head entry is read combinationally
  // so a beat written at one edge is visible on the output during the next cycle.
  always_comb begin
    empty             = (level_q == '0);
    full              = (level_q == LW'(DEPTH));
    head              = mem_q[rd_ptr_q];
    in_entry          = '{data: stream_in_TDATA, keep: stream_in_TKEEP, last: stream_in_TLAST};

    // A full buffer refuses input even when a pop happens in the same cycle.
    stream_in_TREADY  = !full;
    push              = stream_in_TVALID && !full;

    stream_out_TVALID = !empty && ((pkt_count_q != '0) || (state_q == OUT_PKT) || full);
    pop               = stream_out_TVALID && stream_out_TREADY;

    stream_out_TDATA  = head.data;
    stream_out_TKEEP  = head.keep;
    stream_out_TLAST  = stream_out_TVALID && head.last;

    in_last           = push && stream_in_TLAST;
    out_last          = pop && head.last;

    buf_level         = level_q;
  end

  // Pointer, occupancy and stored-packet bookkeeping.
  // NOTE: every signal assigned in a combinational block gets a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pkt_count_d = pkt_count_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (in_last && !out_last)      pkt_count_d = pkt_count_q + 1'b1;
    else if (out_last && !in_last) pkt_count_d = pkt_count_q - 1'b1;
  end

  // Output FSM: tracks whether the router has seen the start of a packet
  // whose TLAST has not yet left, which licenses cut-through of the remainder.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_IDLE: if (pop && !head.last) state_d = OUT_PKT;
      OUT_PKT:  if (pop && head.last)  state_d = OUT_IDLE;
      default:  state_d = OUT_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) state_q <= OUT_IDLE;
    else                   state_q <= state_d;
  end

  // NOTE: the storage array has no reset; clearing the pointers and level is
  // enough to make its contents unreachable, and it keeps the array RAM-mappable.
  always_ff @(posedge clk_line) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

`ifdef NOC_BUF_OUT_STATS_EN
  logic [15:0] pkt_in_cnt_q, pkt_in_cnt_d;
  logic [15:0] pkt_out_cnt_q, pkt_out_cnt_d;

  // Packet counters saturate rather than wrap so a long run never reads as low traffic.
  always_comb begin
    pkt_in_cnt_d  = pkt_in_cnt_q;
    pkt_out_cnt_d = pkt_out_cnt_q;
    if (in_last && (pkt_in_cnt_q != 16'hFFFF))   pkt_in_cnt_d  = pkt_in_cnt_q + 16'd1;
    if (out_last && (pkt_out_cnt_q != 16'hFFFF)) pkt_out_cnt_d = pkt_out_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      pkt_in_cnt_q  <= '0;
      pkt_out_cnt_q <= '0;
    end else begin
      pkt_in_cnt_q  <= pkt_in_cnt_d;
      pkt_out_cnt_q <= pkt_out_cnt_d;
    end
  end

  assign pkt_in_cnt  = pkt_in_cnt_q;
  assign pkt_out_cnt = pkt_out_cnt_q;
`endif

endmodule

// File: tb/tb_noc_buffer_out.sv
// Self-checking bench for noc_buffer_out: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based packet model.
module tb_noc_buffer_out;

  localparam int BW    = 32;
  localparam int BWB   = 4;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic            clk_line = 1'b0;
  logic            clk_line_rst_low = 1'b0;
  logic            in_valid = 1'b0;
  logic [BW-1:0]   in_data = '0;
  logic [BWB-1:0]  in_keep = '0;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic            out_valid;
  logic [BW-1:0]   out_data;
  logic [BWB-1:0]  out_keep;
  logic            out_last;
  logic            out_ready = 1'b0;
  logic [LW-1:0]   buf_level;
`ifdef NOC_BUF_OUT_STATS_EN
  logic [15:0]     pkt_in_cnt;
  logic [15:0]     pkt_out_cnt;
`endif

  noc_buffer_out #(.BW(BW), .BWB(BWB), .DEPTH(DEPTH)) dut (
    .clk_line          (clk_line),
    .clk_line_rst_low  (clk_line_rst_low),
    .stream_in_TVALID  (in_valid),
    .stream_in_TDATA   (in_data),
    .stream_in_TKEEP   (in_keep),
    .stream_in_TLAST   (in_last),
    .stream_in_TREADY  (in_ready),
    .stream_out_TVALID (out_valid),
    .stream_out_TDATA  (out_data),
    .stream_out_TKEEP  (out_keep),
    .stream_out_TLAST  (out_last),
    .stream_out_TREADY (out_ready),
    .buf_level         (buf_level)
`ifdef NOC_BUF_OUT_STATS_EN
    ,
    .pkt_in_cnt        (pkt_in_cnt),
    .pkt_out_cnt       (pkt_out_cnt)
`endif
  );

  always #5 clk_line = ~clk_line;

  typedef struct packed {
    logic [BW-1:0]  data;
    logic [BWB-1:0] keep;
    logic           last;
  } beat_t;

  // Reference model: contents of the buffer, whether a packet is partly sent,
  // saturating packet counters and a log of everything the router received.
  beat_t       model_q[$];
  beat_t       out_log[$];
  bit          model_mid = 1'b0;
  int unsigned stat_in = 0;
  int unsigned stat_out = 0;
  int          first_pop_level = -1;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic int stored_packets();
    int n = 0;
    foreach (model_q[i]) if (model_q[i].last) n++;
    return n;
  endfunction

  // One clock: compare at the falling edge, then advance the model on the rising edge.
  task automatic cycle(output bit accepted);
    bit    ev;
    bit    push;
    bit    pop;
    beat_t b;
    @(negedge clk_line);
    ev = (model_q.size() != 0) &&
         (stored_packets() != 0 || model_mid || model_q.size() == DEPTH);
    vectors++;
    if (out_valid !== ev) begin
      miscompares++;
      $display("FAIL out_valid @%0t: got %b, expected %b", $time, out_valid, ev);
    end
    vectors++;
    if (in_ready !== (model_q.size() != DEPTH)) begin
      miscompares++;
      $display("FAIL in_ready @%0t: got %b, expected %b", $time, in_ready, model_q.size() != DEPTH);
    end
    vectors++;
    if (buf_level !== LW'(model_q.size())) begin
      miscompares++;
      $display("FAIL buf_level @%0t: got %0d, expected %0d", $time, buf_level, model_q.size());
    end
    if (ev) begin
      vectors++;
      if ({out_data, out_keep, out_last} !== model_q[0]) begin
        miscompares++;
        $display("FAIL head_beat @%0t: got %h/%h/%b, expected %h/%h/%b", $time,
                 out_data, out_keep, out_last, model_q[0].data, model_q[0].keep, model_q[0].last);
      end
    end
`ifdef NOC_BUF_OUT_STATS_EN
    vectors++;
    if (pkt_in_cnt !== stat_in[15:0] || pkt_out_cnt !== stat_out[15:0]) begin
      miscompares++;
      $display("FAIL stats @%0t: got %h/%h, expected %h/%h", $time,
               pkt_in_cnt, pkt_out_cnt, stat_in[15:0], stat_out[15:0]);
    end
`endif
    push = in_valid && (model_q.size() != DEPTH);
    pop  = ev && out_ready;
    if (pop && first_pop_level < 0) first_pop_level = model_q.size();
    @(posedge clk_line);
    if (pop) begin
      b = model_q.pop_front();
      out_log.push_back(b);
      model_mid = !b.last;
      if (b.last && stat_out != 32'hFFFF) stat_out++;
    end
    if (push) begin
      model_q.push_back('{data: in_data, keep: in_keep, last: in_last});
      if (in_last && stat_in != 32'hFFFF) stat_in++;
    end
    accepted = push;
    #1;
  endtask

  task automatic run(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic send_beat(input logic [BW-1:0] d, input logic [BWB-1:0] k, input logic l);
    bit acc = 1'b0;
    int budget = 200;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    while (!acc && budget > 0) begin
      cycle(acc);
      budget--;
    end
    in_valid = 1'b0;
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got no acceptance, expected acceptance within 200 cycles");
    end
  endtask

  task automatic drain();
    int budget = 200;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (model_q.size() != 0 && budget > 0) begin
      run(1);
      budget--;
    end
    run(1);
    vectors++;
    if (model_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d beats left, expected 0", model_q.size());
    end
  endtask

  // Asynchronous reset asserted between clock edges, checked while held.
  task automatic apply_reset();
    @(posedge clk_line);
    #3;
    in_valid = 1'b0;
    clk_line_rst_low = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || buf_level !== '0) begin
      miscompares++;
      $display("FAIL in_reset: got valid=%b last=%b level=%0d, expected 0/0/0",
               out_valid, out_last, buf_level);
    end
    model_q.delete();
    model_mid = 1'b0;
    stat_in   = 0;
    stat_out  = 0;
    @(negedge clk_line);
    clk_line_rst_low = 1'b1;
    @(posedge clk_line);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk_line);
      vectors++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || buf_level !== '0) begin
        miscompares++;
        $display("FAIL reset_state: got valid=%b last=%b level=%0d, expected 0/0/0",
                 out_valid, out_last, buf_level);
      end
    end
    @(negedge clk_line);
    clk_line_rst_low = 1'b1;
    @(posedge clk_line);
    #1;
    run(2);
  endtask

  task automatic test_two_beat();
    bit acc;
    out_log.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hA5000000; in_keep = 4'hF; in_last = 1'b0;
    cycle(acc);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL two_beat_early: got valid=%b, expected 0", out_valid);
    end
    in_data = 32'h12345678; in_last = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL two_beat_latency: got valid=%b, expected 1", out_valid);
    end
    drain();
    vectors++;
    if (out_log.size() != 2 || out_log[0].data !== 32'hA5000000 || out_log[0].last !== 1'b0 ||
        out_log[1].data !== 32'h12345678 || out_log[1].last !== 1'b1) begin
      miscompares++;
      $display("FAIL two_beat_order: got %0d beats, expected A5000000 then 12345678 with TLAST on beat 2",
               out_log.size());
    end
  endtask

  task automatic test_fill();
    beat_t sent[$];
    beat_t b;
    out_log.delete();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      b = '{data: $urandom, keep: 4'($urandom), last: 1'b1};
      sent.push_back(b);
      send_beat(b.data, b.keep, 1'b1);
    end
    vectors++;
    if (in_ready !== 1'b0 || buf_level !== LW'(DEPTH)) begin
      miscompares++;
      $display("FAIL fill_full: got ready=%b level=%0d, expected 0/%0d", in_ready, buf_level, DEPTH);
    end
    in_valid = 1'b1; in_data = 32'hDEAD0017; in_keep = 4'hF; in_last = 1'b1;
    run(3);
    in_valid = 1'b0;
    vectors++;
    if (buf_level !== LW'(DEPTH)) begin
      miscompares++;
      $display("FAIL fill_stall: got level=%0d, expected %0d", buf_level, DEPTH);
    end
    drain();
    vectors++;
    if (out_log.size() != DEPTH) begin
      miscompares++;
      $display("FAIL fill_count: got %0d, expected %0d", out_log.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        vectors++;
        if (out_log[i] !== sent[i]) begin
          miscompares++;
          $display("FAIL fill_order[%0d]: got %h, expected %h", i, out_log[i].data, sent[i].data);
        end
      end
    end
  endtask

  task automatic test_cut_through();
    int nlast = 0;
    out_log.delete();
    first_pop_level = -1;
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) send_beat(32'hC0DE0000 + 32'(i), 4'hF, i == 20);
    drain();
    vectors++;
    if (first_pop_level != DEPTH) begin
      miscompares++;
      $display("FAIL cut_through_start: got level %0d at first pop, expected %0d", first_pop_level, DEPTH);
    end
    foreach (out_log[i]) if (out_log[i].last) nlast++;
    vectors++;
    if (out_log.size() != 20 || nlast != 1 || out_log[19].last !== 1'b1 ||
        out_log[19].data !== 32'hC0DE0014 || out_log[0].data !== 32'hC0DE0001) begin
      miscompares++;
      $display("FAIL cut_through_beats: got %0d beats with %0d TLAST, expected 20 with TLAST on beat 20",
               out_log.size(), nlast);
    end
  endtask

  task automatic test_simul_last();
    bit acc;
    out_ready = 1'b0;
    send_beat(32'h11111111, 4'hF, 1'b1);
    in_valid = 1'b1; in_data = 32'h22222222; in_keep = 4'h3; in_last = 1'b1;
    out_ready = 1'b1;
    cycle(acc);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (buf_level !== LW'(1) || dut.pkt_count_q !== LW'(1) || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_last: got level=%0d pkt_count=%0d valid=%b, expected 1/1/1",
               buf_level, dut.pkt_count_q, out_valid);
    end
    drain();
  endtask

  task automatic test_reset_mid_packet();
    out_log.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(32'hBAD00000 + 32'(i), 4'hF, 1'b0);
    apply_reset();
    out_ready = 1'b1;
    send_beat(32'h600D0001, 4'h1, 1'b1);
    drain();
    vectors++;
    if (out_log.size() != 1 || out_log[0].data !== 32'h600D0001 || out_log[0].last !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_packet: got %0d beats, expected only 600D0001", out_log.size());
    end
  endtask

  // Leave the output side mid-packet before reset; afterwards a lone non-TLAST
  // beat must be held back as in a fresh idle buffer.
  task automatic test_reset_fsm();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_beat(32'(i), 4'hF, 1'b0);
    out_ready = 1'b1;
    run(1);
    out_ready = 1'b0;
    apply_reset();
    out_ready = 1'b1;
    send_beat(32'h0000F5A0, 4'hF, 1'b0);
    run(3);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_fsm_idle: got valid=%b, expected 0", out_valid);
    end
    send_beat(32'h0000F5A1, 4'hF, 1'b1);
    drain();
  endtask

  task automatic test_random();
    bit acc;
    for (int blk = 0; blk < 5; blk++) begin
      int rdy_pct = 20 + blk * 20;
      for (int i = 0; i < 300; i++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = $urandom;
        in_keep   = 4'($urandom);
        in_last   = ($urandom_range(0, 4) == 0);
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        cycle(acc);
      end
    end
    in_valid = 1'b0;
    send_beat(32'hE0F0E0F0, 4'hF, 1'b1);
    drain();
  endtask

`ifdef NOC_BUF_OUT_STATS_EN
  task automatic test_stats();
    apply_reset();
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      send_beat(32'h5A000000 + 32'(p), 4'hF, 1'b0);
      send_beat(32'h5B000000 + 32'(p), 4'hF, 1'b1);
    end
    drain();
    vectors++;
    if (pkt_in_cnt !== 16'd3 || pkt_out_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL stats_three: got %0d/%0d, expected 3/3", pkt_in_cnt, pkt_out_cnt);
    end
    @(posedge clk_line);
    #1;
    dut.pkt_in_cnt_q  = 16'hFFFE;
    dut.pkt_out_cnt_q = 16'hFFFE;
    stat_in  = 32'hFFFE;
    stat_out = 32'hFFFE;
    for (int p = 0; p < 3; p++) send_beat(32'h5C000000 + 32'(p), 4'hF, 1'b1);
    drain();
    vectors++;
    if (pkt_in_cnt !== 16'hFFFF || pkt_out_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL stats_saturate: got %h/%h, expected FFFF/FFFF", pkt_in_cnt, pkt_out_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_beat();
    test_fill();
    test_cut_through();
    test_simul_last();
    test_reset_mid_packet();
    test_reset_fsm();
    test_random();
`ifdef NOC_BUF_OUT_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 2 ms");
    $fatal(1, "simulation time limit reached");
  end

endmodule
